// File: rtl/axis_pingpong_pkg.sv
// Shared types and constants for the ping-pong RAM controller: FSM encodings,
// debug word field offsets and the per-bank depth helper.
package axis_pingpong_pkg;

  typedef enum logic [3:0] {
    W_FILL = 4'd0,
    W_WAIT = 4'd1
  } wstate_t;

  typedef enum logic [3:0] {
    R_IDLE  = 4'd0,
    R_READ  = 4'd1,
    R_DRAIN = 4'd2
  } rstate_t;

  localparam int DBG_WST_LSB    = 28;
  localparam int DBG_RST_LSB    = 24;
  localparam int DBG_FULL_LSB   = 22;
  localparam int DBG_FRAMES_LSB = 0;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/pingpong_skid2.sv
// Two-entry output buffer with occupancy count; head entry drives the output.
// Latency: one cycle from in_vld to out_vld.
// Backpressure: none on the input side; the producer must keep count+in-flight within two.
module pingpong_skid2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat,
  output logic [1:0]   count
);

  logic [W-1:0] ent0;
  logic [W-1:0] ent1;
  logic         pop;

  assign pop     = out_vld & out_rdy;
  assign out_vld = (count != 2'd0);
  assign out_dat = ent0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      case ({in_vld, pop})
        2'b10: begin
          if (count == 2'd0) ent0 <= in_dat;
          else               ent1 <= in_dat;
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            ent0 <= in_dat;
          end else begin
            ent0 <= ent1;
            ent1 <= in_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/axis_pingpong_ram_ctrl.sv
// Ping-pong bank controller: steers frame writes into the free bank, reads full banks out as a stream.
// Latency: writes 1 cycle to the RAM port; first output beat 2 cycles after the read FSM starts a bank.
// Backpressure: m_tready stalls RAM reads; wr_allow drops while both banks hold unread frames.
module axis_pingpong_ram_ctrl
  import axis_pingpong_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 10,
  parameter int RD_LAT = 1
) (
  input  logic          S_AXIS_ACLK,
  input  logic          S_AXIS_ARESETN,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_last,
  output logic          wr_allow,
  output logic          ram_wen,
  output logic [AW:0]   ram_waddr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_ren,
  output logic [AW:0]   ram_raddr,
  input  logic [DW-1:0] ram_rdata,
  output logic          m_tvalid,
  output logic [DW-1:0] m_tdata,
  output logic          m_tlast,
  input  logic          m_tready,
  output logic [1:0]    bank_full,
  output logic          overflow,
  output logic [31:0]   debug_state
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(depth_of(AW));

  // The single in-flight flag below assumes a one-cycle RAM.
  if (RD_LAT != 1) begin : g_rd_lat_check
    $error("axis_pingpong_ram_ctrl: only RD_LAT=1 is supported");
  end

  wstate_t       wstate, wstate_nxt;
  rstate_t       rstate, rstate_nxt;
  logic          wbank, wbank_nxt;
  logic          rbank, rbank_nxt;
  logic [AW:0]   wcnt, wcnt_inc;
  logic [AW:0]   len [2];
  logic [AW-1:0] ridx, ridx_nxt;
  logic          in_flight, in_flight_last;
  logic [15:0]   frames_rd;
  logic [1:0]    ob_count;
  logic [2:0]    occ_nxt;
  logic          wr_acc, frame_done, release_bank, issue, last_idx, pop;
  logic [1:0]    full_eff;

  assign pop        = m_tvalid & m_tready;
  assign wr_acc     = wr_en && (wstate == W_FILL);
  assign wcnt_inc   = (wr_acc && (wcnt != DEPTH_L)) ? wcnt + 1'b1 : wcnt;
  assign frame_done = (wstate == W_FILL) && wr_last && (wcnt_inc != '0);

  // A bank is handed back in the cycle its final word leaves the buffer.
  assign release_bank = (rstate == R_DRAIN) && !in_flight &&
                        ((ob_count == 2'd0) || ((ob_count == 2'd1) && pop));
  assign full_eff     = bank_full & ~(release_bank ? (2'b01 << rbank) : 2'b00);

  // Occupancy the buffer will have once this cycle's push/pop settle.
  assign occ_nxt  = {1'b0, ob_count} + {2'b00, in_flight} - {2'b00, pop};
  assign last_idx = ({1'b0, ridx} == (len[rbank] - 1'b1));
  assign issue    = (rstate == R_READ) && (occ_nxt < 3'd2);

  assign ram_ren   = issue;
  assign ram_raddr = {rbank, ridx};

  always_comb begin
    wstate_nxt = wstate;
    wbank_nxt  = wbank;
    case (wstate)
      W_FILL: begin
        if (frame_done) begin
          if (!full_eff[~wbank]) wbank_nxt  = ~wbank;
          else                   wstate_nxt = W_WAIT;
        end
      end
      W_WAIT: begin
        if (!full_eff[~wbank]) begin
          wbank_nxt  = ~wbank;
          wstate_nxt = W_FILL;
        end
      end
      default: wstate_nxt = W_FILL;
    endcase
  end

  always_comb begin
    rstate_nxt = rstate;
    rbank_nxt  = rbank;
    ridx_nxt   = ridx;
    case (rstate)
      R_IDLE: begin
        if (bank_full[rbank]) begin
          ridx_nxt   = '0;
          rstate_nxt = R_READ;
        end
      end
      R_READ: begin
        if (issue) begin
          ridx_nxt = ridx + 1'b1;
          if (last_idx) rstate_nxt = R_DRAIN;
        end
      end
      R_DRAIN: begin
        if (release_bank) begin
          rbank_nxt  = ~rbank;
          rstate_nxt = R_IDLE;
        end
      end
      default: rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      wstate         <= W_FILL;
      rstate         <= R_IDLE;
      wbank          <= 1'b0;
      rbank          <= 1'b0;
      wcnt           <= '0;
      len[0]         <= '0;
      len[1]         <= '0;
      ridx           <= '0;
      bank_full      <= 2'b00;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
      frames_rd      <= 16'd0;
      wr_allow       <= 1'b0;
      overflow       <= 1'b0;
      ram_wen        <= 1'b0;
      ram_waddr      <= '0;
      ram_wdata      <= '0;
    end else begin
      wstate         <= wstate_nxt;
      rstate         <= rstate_nxt;
      wbank          <= wbank_nxt;
      rbank          <= rbank_nxt;
      ridx           <= ridx_nxt;
      in_flight      <= issue;
      in_flight_last <= issue && last_idx;
      wr_allow       <= (wstate_nxt == W_FILL);
      ram_wen        <= wr_acc;
      ram_waddr      <= {wbank, wr_addr};
      ram_wdata      <= wr_data;
      bank_full      <= full_eff | (frame_done ? (2'b01 << wbank) : 2'b00);
      if ((wr_en || wr_last) && (wstate != W_FILL)) overflow <= 1'b1;
      if (frame_done) begin
        len[wbank] <= wcnt_inc;
        wcnt       <= '0;
      end else begin
        wcnt       <= wcnt_inc;
      end
      if (release_bank) frames_rd <= frames_rd + 16'd1;
    end
  end

  pingpong_skid2 #(.W(DW + 1)) u_skid (
    .clk     (S_AXIS_ACLK),
    .rst_n   (S_AXIS_ARESETN),
    .in_vld  (in_flight),
    .in_dat  ({in_flight_last, ram_rdata}),
    .out_vld (m_tvalid),
    .out_rdy (m_tready),
    .out_dat ({m_tlast, m_tdata}),
    .count   (ob_count)
  );

  always_comb begin
    debug_state = '0;
    debug_state[DBG_WST_LSB +: 4]     = wstate;
    debug_state[DBG_RST_LSB +: 4]     = rstate;
    debug_state[DBG_FULL_LSB +: 2]    = bank_full;
    debug_state[DBG_FRAMES_LSB +: 16] = frames_rd;
  end

endmodule

// File: tb/tb_axis_pingpong_ram_ctrl.sv
// Directed bench for axis_pingpong_ram_ctrl with a one-cycle RAM model behind it.
module tb_axis_pingpong_ram_ctrl;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int OUTW  = 2*DW + 32 + 2*(AW+1) + 8;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          wr_en = 1'b0, wr_last = 1'b0, m_tready = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_allow, ram_wen, ram_ren, m_tvalid, m_tlast, overflow;
  logic [AW:0]   ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata, ram_rdata, m_tdata;
  logic [1:0]    bank_full;
  logic [31:0]   debug_state;
  logic [OUTW-1:0] all_out;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  axis_pingpong_ram_ctrl #(.DW(DW), .AW(AW), .RD_LAT(1)) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(arst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
    .wr_allow(wr_allow), .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tready(m_tready),
    .bank_full(bank_full), .overflow(overflow), .debug_state(debug_state)
  );

  assign all_out = {wr_allow, ram_wen, ram_waddr, ram_wdata, ram_ren, ram_raddr,
                    m_tvalid, m_tdata, m_tlast, bank_full, overflow, debug_state};

  logic [DW-1:0] mem [2*DEPTH];
  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    if (ram_ren) ram_rdata <= mem[ram_raddr];
  end

  logic [DW:0] beats_q [$];
  logic [AW:0] waddr_q [$];
  int          stall_viol = 0;
  int          f3_wr = 0;
  logic        prev_stall = 1'b0;
  logic [DW:0] prev_beat = '0;

  always @(negedge clk) begin
    if (!arst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_tvalid || ({m_tlast, m_tdata} !== prev_beat))) stall_viol++;
      if (m_tvalid && m_tready) beats_q.push_back({m_tlast, m_tdata});
      if (ram_wen) waddr_q.push_back(ram_waddr);
      if (ram_wen && ram_wdata[31:28] == 4'h3) f3_wr++;
      prev_stall = m_tvalid && !m_tready;
      prev_beat  = {m_tlast, m_tdata};
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    arst_n = 1'b0; wr_en = 1'b0; wr_last = 1'b0; wr_addr = '0; wr_data = '0; m_tready = 1'b0;
    step(2);
    arst_n = 1'b1;
    step(2);
    beats_q.delete(); waddr_q.delete(); stall_viol = 0; f3_wr = 0;
  endtask

  task automatic write_frame(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = base + DW'(i); wr_last = (i == n-1);
      step(1);
    end
    wr_en = 1'b0; wr_last = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int lim);
    int c = 0;
    while (beats_q.size() < n && c < lim) begin
      step(1);
      c++;
    end
  endtask

  task automatic test_reset;
    arst_n = 1'b0;
    step(1);
    vecs++;
    if (all_out !== '0) begin errs++; $display("FAIL reset_outputs: got %h, want 0", all_out); end
    arst_n = 1'b1;
    step(1);
    vecs++;
    if ({wr_allow, bank_full, overflow, m_tvalid} !== 5'b10000) begin
      errs++; $display("FAIL post_reset_state: got %b, want 10000", {wr_allow, bank_full, overflow, m_tvalid});
    end
  endtask

  task automatic test_basic_frame;
    logic [DW:0] e;
    do_reset();
    m_tready = 1'b1;
    write_frame(4, 32'hA0);
    wait_beats(4, 50);
    step(3);
    vecs++;
    if (waddr_q.size() != 4) begin errs++; $display("FAIL basic_wcount: got %0d, want 4", waddr_q.size()); end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (i >= waddr_q.size() || waddr_q[i] !== (AW+1)'(i)) begin
        errs++; $display("FAIL basic_waddr[%0d]: got %h, want %h", i, (i < waddr_q.size()) ? waddr_q[i] : '1, i);
      end
    end
    vecs++;
    if (beats_q.size() != 4) begin errs++; $display("FAIL basic_beats: got %0d, want 4", beats_q.size()); end
    for (int i = 0; i < 4; i++) begin
      e = {(i == 3), DW'(32'hA0 + i)};
      vecs++;
      if (i >= beats_q.size() || beats_q[i] !== e) begin
        errs++; $display("FAIL basic_beat[%0d]: got %h, want %h", i, (i < beats_q.size()) ? beats_q[i] : '1, e);
      end
    end
    vecs++;
    if (bank_full !== 2'b00) begin errs++; $display("FAIL basic_bank_full: got %b, want 00", bank_full); end
    vecs++;
    if (debug_state !== 32'h0000_0001) begin errs++; $display("FAIL basic_debug: got %h, want 00000001", debug_state); end
  endtask

  task automatic test_overflow;
    int c = 0;
    int bad = 0;
    int first_bad = -1;
    logic seen = 1'b0;
    logic [DW:0] e;
    do_reset();
    write_frame(DEPTH, 32'h1000_0000);
    write_frame(DEPTH, 32'h2000_0000);
    vecs++;
    if (wr_allow !== 1'b0) begin errs++; $display("FAIL ovf_allow_drop: got %b, want 0", wr_allow); end
    vecs++;
    if (bank_full !== 2'b11) begin errs++; $display("FAIL ovf_both_full: got %b, want 11", bank_full); end
    write_frame(DEPTH, 32'h3000_0000);
    step(2);
    vecs++;
    if (overflow !== 1'b1) begin errs++; $display("FAIL ovf_sticky: got %b, want 1", overflow); end
    vecs++;
    if (f3_wr != 0) begin errs++; $display("FAIL ovf_dropped: got %0d frame-3 writes, want 0", f3_wr); end
    m_tready = 1'b1;
    while (!seen && c < 3000) begin
      @(negedge clk);
      if (m_tvalid && m_tlast && m_tdata[31:28] == 4'h1) seen = 1'b1;
      else c++;
    end
    vecs++;
    if (!seen) begin errs++; $display("FAIL ovf_bank0_last: got timeout, want last beat of bank 0"); end
    vecs++;
    if (wr_allow !== 1'b0) begin errs++; $display("FAIL ovf_allow_before_release: got %b, want 0", wr_allow); end
    step(1);
    vecs++;
    if (wr_allow !== 1'b1) begin errs++; $display("FAIL ovf_allow_after_release: got %b, want 1", wr_allow); end
    wait_beats(2*DEPTH, 3000);
    step(3);
    vecs++;
    if (beats_q.size() != 2*DEPTH) begin errs++; $display("FAIL ovf_beats: got %0d, want %0d", beats_q.size(), 2*DEPTH); end
    for (int i = 0; i < beats_q.size(); i++) begin
      e = (i < DEPTH) ? {(i == DEPTH-1), DW'(32'h1000_0000 + i)} : {(i == 2*DEPTH-1), DW'(32'h2000_0000 + i - DEPTH)};
      if (beats_q[i] !== e) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    end
    vecs++;
    if (bad != 0) begin errs++; $display("FAIL ovf_stream: got %0d bad beats (first %0d), want 0", bad, first_bad); end
    vecs++;
    if ({overflow, bank_full, debug_state[15:0]} !== {1'b1, 2'b00, 16'd2}) begin
      errs++; $display("FAIL ovf_end_state: got ovf=%b full=%b frames=%0d, want 1 00 2", overflow, bank_full, debug_state[15:0]);
    end
  endtask

  task automatic test_random_stall;
    int c = 0;
    logic [DW:0] e;
    do_reset();
    write_frame(16, 32'hB00);
    while (beats_q.size() < 16 && c < 500) begin
      m_tready = 1'($urandom_range(0, 1));
      step(1);
      c++;
    end
    m_tready = 1'b1;
    step(3);
    vecs++;
    if (beats_q.size() != 16) begin errs++; $display("FAIL stall_count: got %0d, want 16", beats_q.size()); end
    for (int i = 0; i < 16; i++) begin
      e = {(i == 15), DW'(32'hB00 + i)};
      vecs++;
      if (i >= beats_q.size() || beats_q[i] !== e) begin
        errs++; $display("FAIL stall_beat[%0d]: got %h, want %h", i, (i < beats_q.size()) ? beats_q[i] : '1, e);
      end
    end
    vecs++;
    if (stall_viol != 0) begin errs++; $display("FAIL stall_hold: got %0d unstable stalls, want 0", stall_viol); end
  endtask

  task automatic test_zero_and_single;
    do_reset();
    m_tready = 1'b1;
    wr_last = 1'b1;
    step(1);
    wr_last = 1'b0;
    vecs++;
    if (bank_full !== 2'b00) begin errs++; $display("FAIL zero_len_full: got %b, want 00", bank_full); end
    step(6);
    vecs++;
    if ({beats_q.size() != 0, waddr_q.size() != 0, overflow} !== 3'b000) begin
      errs++; $display("FAIL zero_len_quiet: got beats=%0d writes=%0d ovf=%b, want 0 0 0", beats_q.size(), waddr_q.size(), overflow);
    end
    write_frame(1, 32'h55);
    wait_beats(1, 20);
    step(3);
    vecs++;
    if (beats_q.size() != 1) begin errs++; $display("FAIL single_count: got %0d, want 1", beats_q.size()); end
    vecs++;
    if (beats_q.size() < 1 || beats_q[0] !== {1'b1, 32'h55}) begin
      errs++; $display("FAIL single_beat: got %h, want 100000055", (beats_q.size() > 0) ? beats_q[0] : '1);
    end
    vecs++;
    if ({bank_full, debug_state[15:0]} !== {2'b00, 16'd1}) begin
      errs++; $display("FAIL single_release: got full=%b frames=%0d, want 00 1", bank_full, debug_state[15:0]);
    end
  endtask

  task automatic test_back_to_back;
    logic allow_all = 1'b1;
    logic [DW:0] exp_b [6];
    exp_b[0] = {1'b0, 32'hD0}; exp_b[1] = {1'b1, 32'hD1};
    exp_b[2] = {1'b0, 32'hE0}; exp_b[3] = {1'b0, 32'hE1};
    exp_b[4] = {1'b0, 32'hE2}; exp_b[5] = {1'b1, 32'hE3};
    do_reset();
    write_frame(2, 32'hD0);
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_addr = AW'(i); wr_data = 32'hE0 + DW'(i);
      step(1);
      allow_all &= wr_allow;
    end
    wr_en = 1'b0;
    step(4);
    allow_all &= wr_allow;
    m_tready = 1'b1;
    step(1);
    allow_all &= wr_allow;
    wr_en = 1'b1; wr_addr = 3; wr_data = 32'hE3; wr_last = 1'b1;
    step(1);
    wr_last = 1'b0;
    allow_all &= wr_allow;
    vecs++;
    if (bank_full !== 2'b10) begin errs++; $display("FAIL b2b_full: got %b, want 10", bank_full); end
    wr_addr = 0; wr_data = 32'hF0;
    step(1);
    wr_en = 1'b0;
    allow_all &= wr_allow;
    vecs++;
    if ({ram_wen, ram_waddr} !== {1'b1, 11'h000}) begin
      errs++; $display("FAIL b2b_wbank: got wen=%b waddr=%h, want 1 000", ram_wen, ram_waddr);
    end
    vecs++;
    if (allow_all !== 1'b1) begin errs++; $display("FAIL b2b_allow: got a drop of wr_allow, want steady 1"); end
    wait_beats(6, 50);
    step(3);
    vecs++;
    if (beats_q.size() != 6) begin errs++; $display("FAIL b2b_count: got %0d, want 6", beats_q.size()); end
    for (int i = 0; i < 6; i++) begin
      vecs++;
      if (i >= beats_q.size() || beats_q[i] !== exp_b[i]) begin
        errs++; $display("FAIL b2b_beat[%0d]: got %h, want %h", i, (i < beats_q.size()) ? beats_q[i] : '1, exp_b[i]);
      end
    end
  endtask

  task automatic test_reset_mid_readout;
    int c = 0;
    logic [DW:0] e;
    do_reset();
    m_tready = 1'b1;
    write_frame(16, 32'h700);
    while (beats_q.size() < 5 && c < 100) begin
      step(1);
      c++;
    end
    vecs++;
    if (beats_q.size() != 5) begin errs++; $display("FAIL midrst_reach: got %0d beats, want 5", beats_q.size()); end
    arst_n = 1'b0;
    #1;
    vecs++;
    if (all_out !== '0) begin errs++; $display("FAIL midrst_async: got %h, want 0", all_out); end
    step(2);
    arst_n = 1'b1;
    step(2);
    beats_q.delete(); waddr_q.delete();
    write_frame(4, 32'hC0);
    wait_beats(4, 50);
    step(3);
    vecs++;
    if (waddr_q.size() < 1 || waddr_q[0] !== 11'h000) begin
      errs++; $display("FAIL midrst_bank0: got %h, want 000", (waddr_q.size() > 0) ? waddr_q[0] : '1);
    end
    vecs++;
    if (beats_q.size() != 4) begin errs++; $display("FAIL midrst_count: got %0d, want 4", beats_q.size()); end
    for (int i = 0; i < 4; i++) begin
      e = {(i == 3), DW'(32'hC0 + i)};
      vecs++;
      if (i >= beats_q.size() || beats_q[i] !== e) begin
        errs++; $display("FAIL midrst_beat[%0d]: got %h, want %h", i, (i < beats_q.size()) ? beats_q[i] : '1, e);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_overflow();
    test_random_stall();
    test_zero_and_single();
    test_back_to_back();
    test_reset_mid_readout();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/axis_pingpong_ram_ctrl.md
Name: axis_pingpong_ram_ctrl

Overview:
- Controller between the AXI-Stream slave write interface and a 2-bank (ping-pong) block RAM.
- Steers each incoming frame's RAM writes into the free bank and records each frame's length.
- Schedules readout of full banks as an AXI-Stream-style master stream, and throttles the writer when both banks are occupied.
- Lets the writer fill one bank while the consumer drains the other.

Parameters:
- DW, 32, data width
- AW, 10, per-bank address width; DEPTH = 2**AW words per bank
- RD_LAT, 1, RAM read latency in cycles; only the value 1 is supported

Ports:
- S_AXIS_ACLK  in  1  clock
- S_AXIS_ARESETN  in  1  reset
- wr_en  in  1  write strobe from the stream interface
- wr_addr  in  AW  word index within the frame
- wr_data  in  DW  write data
- wr_last  in  1  frame-end pulse; may coincide with the last wr_en
- wr_allow  out  1  1 = a bank is available; upstream gates TREADY with this
- ram_wen  out  1  RAM write enable
- ram_waddr  out  AW+1  {bank, wr_addr}
- ram_wdata  out  DW  RAM write data
- ram_ren  out  1  RAM read enable
- ram_raddr  out  AW+1  {bank, index}
- ram_rdata  in  DW  RAM read data, valid RD_LAT cycles after ram_ren
- m_tvalid  out  1  output stream valid
- m_tdata  out  DW  output stream data
- m_tlast  out  1  marks the last word of a bank
- m_tready  in  1  output stream ready
- bank_full  out  2  per-bank full flags
- overflow  out  1  sticky: a write or frame arrived while wr_allow=0
- debug_state  out  32  [31:28] write state, [27:24] read state, [23:22] bank_full, [15:0] frames read (wraps)

Behaviour:
- Reset is asynchronous and active-low (S_AXIS_ARESETN); single clock S_AXIS_ACLK.
- All outputs reset to 0. wbank, rbank, lengths and counters also reset to 0.
- Reset mid-frame discards all banks and both lengths; no partial frame is ever read out.
- Write path latency is 1 cycle: ram_wen/ram_waddr/ram_wdata are registered copies of wr_en/{wbank,wr_addr}/wr_data.
- A write passes only when state=W_FILL; otherwise it is dropped and overflow is set.
- wcnt (AW+1 bits) counts accepted writes and saturates at DEPTH.
- Write FSM:
  - W_FILL (wr_allow=1): on wr_last with wcnt_next>0:
    - len[wbank] <= wcnt_next; bank_full[wbank] <= 1; wcnt <= 0.
    - If bank_full[~wbank]=0 (after same-cycle release), wbank <= ~wbank and stay in W_FILL; else go to W_WAIT.
  - A wr_last with wcnt_next=0 (zero-length frame) is ignored.
  - W_WAIT (wr_allow=0): when bank_full[~wbank] clears, wbank <= ~wbank and go to W_FILL.
  - wr_last in W_WAIT sets overflow.
- Read FSM (starts with the oldest full bank; rbank alternates):
  - R_IDLE: if bank_full[rbank], ridx <= 0 and go to R_READ.
  - R_READ: issue ram_ren with ram_raddr={rbank,ridx} only when outbuf_count + in_flight < 2; ridx increments on each issue. When ridx reaches len[rbank]-1 and that read is issued, go to R_DRAIN.
  - R_DRAIN: when in_flight=0 and the output buffer is empty, clear bank_full[rbank], rbank <= ~rbank, go to R_IDLE.
- Output buffer is a 2-entry skid. m_tvalid = buffer not empty. m_tlast marks the word with index len-1. A word is popped on m_tvalid && m_tready.
- m_tdata/m_tlast must hold stable while m_tvalid && !m_tready.
- Simultaneous events:
  - Bank release and wr_last in the same cycle: the writer sees the bank as free and switches with no stall cycle.
  - Set and clear of the same bank_full bit cannot coincide, because the write and read banks differ whenever both are active.
- Throughput: with m_tready held at 1, one word per cycle after a 2-cycle start-up (issue, then RAM).
- Length 1 frame: R_READ issues once, goes straight to R_DRAIN, and m_tlast is set on that word.

Decomposition:
- Package axis_pingpong_pkg holds:
  - write-state enum (W_FILL, W_WAIT) and read-state enum (R_IDLE, R_READ, R_DRAIN);
  - debug field offsets;
  - DEPTH localparam helper.
- One sub-module, pingpong_skid2: the 2-entry output buffer with occupancy count, reusable elsewhere.

Test Plan:
- Reset, then a 4-word frame (data 0xA0..0xA3, wr_last on the 4th word), m_tready=1:
  - ram_waddr 0x000..0x003 in bank 0;
  - m_tdata A0..A3, m_tlast on A3;
  - bank_full returns to 00.
- Three 1024-word frames back-to-back with m_tready=0:
  - frames 1 and 2 fill banks 0 and 1;
  - wr_allow drops after frame 2;
  - frame 3 writes are dropped and overflow=1;
  - raising m_tready releases bank 0 and wr_allow=1 in the cycle after the bank 0 m_tlast is accepted.
- Random m_tready (50%) during a 16-word readout: every word is delivered exactly once, in order, and data is stable while stalled.
- Writer finishes a frame into bank 1 in the same cycle the reader releases bank 0: wbank=0 next cycle and wr_allow stays 1 throughout.
- wr_last with no prior writes: no bank_full change and no output. A 1-word frame (0x55): a single beat with m_tlast=1.
- Assert S_AXIS_ARESETN=0 mid-readout at word 5: all outputs are 0 immediately (asynchronous), and after release the next frame starts in bank 0.
